// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline family of blocks.
package pipe_pkg;
  localparam int PIPE_WIDTH = 16;
  localparam int PIPE_DEPTH = 3;

  // Width needed to hold an occupancy value in 0..depth.
  function automatic int pipe_cw(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// One valid/data register pair of the elastic pipeline.
module pipe_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_ld,
  input  logic             i_v,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_v,
  output logic [WIDTH-1:0] o_d
);
  logic             r_v;
  logic [WIDTH-1:0] r_d;

  // Data is only captured alongside a valid word; bubbles leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (i_flush) begin
      r_v <= 1'b0;
    end else if (i_ld) begin
      r_v <= i_v;
      if (i_v) r_d <= i_d;
    end
  end

  assign o_v = r_v;
  assign o_d = r_d;
endmodule

// File: rtl/pipe_delay.sv
// Elastic DEPTH-stage delay line with valid/ready handshake, bubble
// collapsing under backpressure, synchronous flush and occupancy count.
module pipe_delay
  import pipe_pkg::*;
#(
  parameter  int WIDTH = PIPE_WIDTH,
  parameter  int DEPTH = PIPE_DEPTH,
  localparam int CW    = pipe_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0]            w_v;
  logic [DEPTH-1:0][WIDTH-1:0] w_d;
  logic [DEPTH-1:0]            w_vin;
  logic [DEPTH-1:0][WIDTH-1:0] w_din;
  logic [DEPTH-1:0]            w_ld;
  logic                        w_in_hs;
  logic                        w_out_hs;
  logic [CW-1:0]               r_count;

  // Stage i may load when it is empty or everything ahead of it moves;
  // folding from the output side keeps the chain free of self-reads.
  always_comb begin
    logic l_ok;
    l_ok = out_ready;
    w_ld = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      l_ok    = l_ok | ~w_v[i];
      w_ld[i] = l_ok;
    end
  end

  assign in_ready  = w_ld[0] & ~flush;
  assign w_in_hs   = in_valid & in_ready;
  assign w_out_hs  = w_v[DEPTH-1] & out_ready;
  assign out_valid = w_v[DEPTH-1];
  assign data_out  = w_d[DEPTH-1];
  assign count     = r_count;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    if (i == 0) begin : g_head
      assign w_vin[i] = w_in_hs;
      assign w_din[i] = data_in;
    end else begin : g_body
      assign w_vin[i] = w_v[i-1];
      assign w_din[i] = w_d[i-1];
    end
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_ld    (w_ld[i]),
      .i_v     (w_vin[i]),
      .i_d     (w_din[i]),
      .o_v     (w_v[i]),
      .o_d     (w_d[i])
    );
  end

  // Occupancy tracks the handshakes so it equals popcount(v) after each edge.
  always_ff @(posedge clk) begin
    if (rst || flush) r_count <= '0;
    else              r_count <= r_count + CW'(w_in_hs) - CW'(w_out_hs);
  end
endmodule

// File: tb/tb_pipe_delay.sv
// Randomized + directed bench for pipe_delay against a word/position queue model.
module tb_pipe_delay;
  localparam int WIDTH = 16;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] data_in, data_out;
  logic [CW-1:0]    count;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  // Model: in-flight words with their stage position (0 = input side).
  int               mpos[$];
  logic [WIDTH-1:0] mdat[$];

  pipe_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_front_valid();
    return mpos.size() > 0 && mpos[0] == DEPTH - 1;
  endfunction

  // Positions after one edge: pop if delivered, then each word moves up one
  // unless blocked by the word ahead or by the output end.
  function automatic void m_advance(input bit ordy, output int np[$], output bit pop);
    int lim;
    np  = mpos;
    pop = m_front_valid() && ordy;
    if (pop) void'(np.pop_front());
    for (int k = 0; k < np.size(); k++) begin
      lim   = (k == 0) ? DEPTH - 1 : np[k-1] - 1;
      np[k] = (np[k] + 1 < lim) ? np[k] + 1 : lim;
    end
  endfunction

  function automatic bit m_in_ready();
    int np[$];
    bit pop;
    m_advance(out_ready, np, pop);
    return !flush && (np.size() == 0 || np[np.size()-1] != 0);
  endfunction

  task automatic m_edge();
    int np[$];
    bit pop, ir;
    ir = m_in_ready();
    if (rst) begin
      mpos.delete(); mdat.delete();
    end else begin
      m_advance(out_ready, np, pop);
      if (pop) void'(mdat.pop_front());
      if (flush) begin
        mpos.delete(); mdat.delete();
      end else begin
        mpos = np;
        if (in_valid && ir) begin
          mpos.push_back(0);
          mdat.push_back(data_in);
        end
      end
    end
  endtask

  task automatic compare();
    chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
    chk("out_valid", 32'(out_valid), 32'(m_front_valid()));
    chk("count", 32'(count), 32'(mpos.size()));
    if (m_front_valid()) chk("data_out", 32'(data_out), 32'(mdat[0]));
  endtask

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [WIDTH-1:0] din, input logic ordy);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; data_in = din; out_ready = ordy;
    #1;
    if (started) compare();
    m_edge();
    @(posedge clk);
    #1;
    started = 1;
  endtask

  task automatic pin(input string name, input logic ov, input logic [WIDTH-1:0] dout,
                     input int cnt);
    chk({name, ".out_valid"}, 32'(out_valid), 32'(ov));
    if (ov) chk({name, ".data_out"}, 32'(data_out), 32'(dout));
    chk({name, ".count"}, 32'(count), 32'(cnt));
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; data_in = '0; out_ready = 1;

    // Reset held with a word offered at the input
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 16'h00AA, 1);
      pin("reset", 0, '0, 0);
      chk("reset.data_out_zero", 32'(data_out), 32'h0);
    end
    step(0, 0, 0, '0, 1);
    pin("post_reset", 0, '0, 0);
    chk("post_reset.data_out_zero", 32'(data_out), 32'h0);

    // Latency and throughput
    step(0, 0, 1, 16'd1, 1);
    step(0, 0, 1, 16'd12, 1);
    step(0, 0, 1, 16'd3, 1);
    pin("lat1", 1, 16'd1, 3);
    step(0, 0, 0, '0, 1);  pin("lat12", 1, 16'd12, 2);
    step(0, 0, 0, '0, 1);  pin("lat3", 1, 16'd3, 1);
    step(0, 0, 0, '0, 1);  pin("lat_empty", 0, '0, 0);

    // Backpressure until full, then drain in order
    step(0, 0, 1, 16'd5, 0);
    step(0, 0, 1, 16'd6, 0);
    step(0, 0, 1, 16'd7, 0);
    pin("full", 1, 16'd5, 3);
    step(0, 0, 1, 16'd8, 0);
    pin("full_hold", 1, 16'd5, 3);
    chk("full.in_ready", 32'(in_ready), 32'h0);
    step(0, 0, 1, 16'd8, 1); pin("drain6", 1, 16'd6, 3);
    step(0, 0, 0, '0, 1);    pin("drain7", 1, 16'd7, 2);
    step(0, 0, 0, '0, 1);    pin("drain8", 1, 16'd8, 1);
    step(0, 0, 0, '0, 1);    pin("drain_empty", 0, '0, 0);

    // Bubble collapse under stall
    step(0, 0, 1, 16'd9, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 1, 16'd10, 0);
    step(0, 0, 0, '0, 0);
    pin("bubble", 1, 16'd9, 2);
    step(0, 0, 0, '0, 1);    pin("bubble10", 1, 16'd10, 1);
    step(0, 0, 0, '0, 1);    pin("bubble_empty", 0, '0, 0);

    // Flush drops everything in flight and the offered word
    step(0, 0, 1, 16'd1, 0);
    step(0, 0, 1, 16'd2, 0);
    step(0, 0, 1, 16'd3, 0);
    step(0, 1, 1, 16'd4, 0);
    pin("flush", 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, '0, 1);
      pin("flush_quiet", 0, '0, 0);
    end

    // Simultaneous in/out when full
    step(0, 0, 1, 16'd11, 0);
    step(0, 0, 1, 16'd12, 0);
    step(0, 0, 1, 16'd13, 0);
    step(0, 0, 1, 16'd20, 1); pin("simul", 1, 16'd12, 3);
    step(0, 0, 0, '0, 1);     pin("simul13", 1, 16'd13, 2);
    step(0, 0, 0, '0, 1);     pin("simul20", 1, 16'd20, 1);
    step(0, 0, 0, '0, 1);

    // Reset mid-stream
    step(0, 0, 1, 16'h55, 0);
    step(0, 0, 1, 16'h66, 0);
    step(1, 0, 1, 16'h77, 1);
    pin("rst_mid", 0, '0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0), WIDTH'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    step(0, 0, 0, '0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
